// File: rtl/flash_ctrl_pkg.sv
// Shared types and constants for the serial flash read path.
package flash_ctrl_pkg;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned TOTAL_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } fsm_state_t;

  // Bytes arrive in address order; the first one lands in the low byte.
  function automatic logic [DATA_BITS-1:0] byte_swap32(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module flash_rr_arb (
  input  logic [1:0] valids,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = valids;
    if (valids == 2'b11) begin
      grant = last_id ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter issuing SPI mode-0 0x03 reads (cmd, 24-bit addr, 32 data bits).
module flash_read_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic [1:0]           req_valid,
  input  logic [ADDR_BITS-1:0] req_addr0,
  input  logic [ADDR_BITS-1:0] req_addr1,
  output logic [1:0]           req_ready,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rid,
  output logic                 rvalid,
  output logic                 flash_csb,
  output logic                 flash_clk,
  output logic                 flash_io0,
  input  logic                 flash_io1
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] BIT_LAST = 7'(TOTAL_BITS - 1);

  fsm_state_t state_q, state_d;

  logic [7:0]            div_cnt;
  logic                  phase;
  logic [6:0]            bit_cnt;
  logic [TOTAL_BITS-1:0] tx_sr;
  logic [DATA_BITS-1:0]  rx_sr, rx_next;
  logic                  last_id, cur_id;
  logic [1:0]            grant;
  logic                  accept, bit_end, capture, xfer_done;

  flash_rr_arb u_arb (
    .valids  (req_valid),
    .last_id (last_id),
    .grant   (grant)
  );

  // GAP reuses the bit timer: one bit period is exactly 2*CLK_DIV cycles.
  assign bit_end   = phase && (div_cnt == DIV_LAST);
  assign capture   = (state_q == XFER) && phase && (div_cnt == '0);
  assign xfer_done = (state_q == XFER) && bit_end && (bit_cnt == BIT_LAST);
  assign rx_next   = capture ? {rx_sr[DATA_BITS-2:0], flash_io1} : rx_sr;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    flash_csb = 1'b1;
    flash_clk = 1'b0;
    flash_io0 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (resetb && (req_valid != 2'b00)) begin
          accept    = 1'b1;
          req_ready = grant;
          state_d   = XFER;
        end
      end
      XFER: begin
        flash_csb = 1'b0;
        flash_clk = phase;
        flash_io0 = tx_sr[TOTAL_BITS-1];
        if (xfer_done) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      last_id <= 1'b1;
      cur_id  <= 1'b0;
      rdata   <= '0;
      rid     <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (accept) begin
        tx_sr   <= {CMD_READ, (grant[1] ? req_addr1 : req_addr0), {DATA_BITS{1'b0}}};
        cur_id  <= grant[1];
        last_id <= grant[1];
        div_cnt <= '0;
        phase   <= 1'b0;
        bit_cnt <= '0;
      end else if (state_q != IDLE) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (state_q == XFER) begin
          rx_sr <= rx_next;
          if (bit_end) begin
            tx_sr   <= {tx_sr[TOTAL_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 7'd1;
          end
          // With CLK_DIV=1 the last sample and the final bit end share an edge.
          if (xfer_done) begin
            rvalid  <= 1'b1;
            rdata   <= byte_swap32(rx_next);
            rid     <= cur_id;
            bit_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench: two instances (CLK_DIV=2 and 1), flash slave model, timing-level reference model.
`timescale 1ns/1ps
module tb_flash_read_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetb    [2];
  logic [1:0]  req_valid [2];
  logic [23:0] req_addr0 [2];
  logic [23:0] req_addr1 [2];
  logic [1:0]  req_ready [2];
  logic [31:0] rdata     [2];
  logic        rid       [2];
  logic        rvalid    [2];
  logic        flash_csb [2];
  logic        flash_clk [2];
  logic        flash_io0 [2];
  logic        flash_io1 [2];

  flash_read_arbiter #(.CLK_DIV(2)) dut_div2 (
    .clock(clock), .resetb(resetb[0]), .req_valid(req_valid[0]),
    .req_addr0(req_addr0[0]), .req_addr1(req_addr1[0]), .req_ready(req_ready[0]),
    .rdata(rdata[0]), .rid(rid[0]), .rvalid(rvalid[0]), .flash_csb(flash_csb[0]),
    .flash_clk(flash_clk[0]), .flash_io0(flash_io0[0]), .flash_io1(flash_io1[0])
  );

  flash_read_arbiter #(.CLK_DIV(1)) dut_div1 (
    .clock(clock), .resetb(resetb[1]), .req_valid(req_valid[1]),
    .req_addr0(req_addr0[1]), .req_addr1(req_addr1[1]), .req_ready(req_ready[1]),
    .rdata(rdata[1]), .rid(rid[1]), .rvalid(rvalid[1]), .flash_csb(flash_csb[1]),
    .flash_clk(flash_clk[1]), .flash_io0(flash_io0[1]), .flash_io1(flash_io1[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Flash contents: address 0x000100 reads back DE AD BE EF.
  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return 32'hDEADBEEF ^ {8'h00, a ^ 24'h000100};
  endfunction

  function automatic logic [31:0] le_pack(input logic [31:0] w);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) o[8*b +: 8] = w[31-8*b -: 8];
    return o;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  // Requesters: present queued addresses, hold each until accepted.
  logic [23:0] alist  [2][2][8];
  int          wr_ptr [2][2] = '{default: 0};
  int          rd_ptr [2][2];
  logic        seen   [2][2];

  task automatic push(input int i, input int r, input logic [23:0] a);
    alist[i][r][wr_ptr[i][r]] = a;
    wr_ptr[i][r]++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 2'b00;
      req_addr0[i] = '0;
      req_addr1[i] = '0;
      for (int r = 0; r < 2; r++) rd_ptr[i][r] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++) seen[i][r] = req_ready[i][r];
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++) begin
          if (req_valid[i][r] && seen[i][r]) req_valid[i][r] = 1'b0;
          if (!req_valid[i][r] && rd_ptr[i][r] < wr_ptr[i][r]) begin
            req_valid[i][r] = 1'b1;
            if (r == 0) req_addr0[i] = alist[i][r][rd_ptr[i][r]];
            else        req_addr1[i] = alist[i][r][rd_ptr[i][r]];
            rd_ptr[i][r]++;
          end
        end
    end
  end

  // Flash slave: capture MOSI on rising flash_clk, drive MISO after falling flash_clk.
  int          rises       [2];
  logic [63:0] mosi        [2];
  logic        prev_clk    [2];
  int          rise_cyc    [2];
  int          rise_period [2];
  logic [31:0] resp        [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      flash_io1[i] = 1'b0; rises[i] = 0; mosi[i] = '0; prev_clk[i] = 1'b0;
      rise_cyc[i] = 0; rise_period[i] = 0; resp[i] = '0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (flash_csb[i] !== 1'b0) begin
          rises[i] = 0;
          prev_clk[i] = 1'b0;
        end else begin
          if (flash_clk[i] && !prev_clk[i] && rises[i] < 64) begin
            mosi[i][63-rises[i]] = flash_io0[i];
            rise_period[i] = cyc - rise_cyc[i];
            rise_cyc[i] = cyc;
            rises[i]++;
            if (rises[i] == 32) resp[i] = flash_word(mosi[i][55:32]);
          end
          if (!flash_clk[i] && prev_clk[i] && rises[i] >= 32 && rises[i] < 64)
            flash_io1[i] = resp[i][63-rises[i]];
          prev_clk[i] = flash_clk[i];
        end
      end
    end
  end

  // Event log used by the hand-computed checks.
  int          acc_cnt [2];
  int          acc_cyc [2][16];
  int          rv_cnt  [2];
  int          rv_cyc  [2][16];
  logic [31:0] rv_dat  [2][16];
  logic        rv_id   [2][16];
  logic [31:0] rv_cmd  [2][16];

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0;
      rv_cnt[i]  = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i] != 2'b00 && acc_cnt[i] < 16) begin
          acc_cyc[i][acc_cnt[i]] = cyc;
          acc_cnt[i]++;
        end
        if (rvalid[i] && rv_cnt[i] < 16) begin
          rv_cyc[i][rv_cnt[i]] = cyc;
          rv_dat[i][rv_cnt[i]] = rdata[i];
          rv_id[i][rv_cnt[i]]  = rid[i];
          rv_cmd[i][rv_cnt[i]] = mosi[i][63:32];
          rv_cnt[i]++;
        end
      end
    end
  end

  // Reference model: a transfer accepted at T0 owns csb for 128*D cycles,
  // reports at T0+1+128*D, then blocks accepts for another 2*D cycles.
  logic        armed   [2];
  logic        busy    [2];
  int          t0      [2];
  logic        lastp   [2];
  logic [23:0] m_addr  [2];
  logic        m_id    [2];
  logic [31:0] h_data  [2];
  logic        h_id    [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      armed[i] = 1'b0; busy[i] = 1'b0; t0[i] = 0; lastp[i] = 1'b1;
      m_addr[i] = '0; m_id[i] = 1'b0; h_data[i] = '0; h_id[i] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        int d, rel, g, idx;
        logic in_xfer, done, free_now, exp_clk;
        logic [1:0]  exp_ready;
        logic [31:0] cmdaddr;
        d        = div_of(i);
        rel      = cyc - t0[i];
        in_xfer  = busy[i] && rel >= 1 && rel <= 128*d;
        done     = busy[i] && rel == 128*d + 1;
        free_now = !busy[i] || rel >= 128*d + 1 + 2*d;
        if (done) begin
          h_data[i] = le_pack(flash_word(m_addr[i]));
          h_id[i]   = m_id[i];
        end
        g = 0;
        exp_ready = 2'b00;
        if (resetb[i] && free_now && req_valid[i] != 2'b00) begin
          if (req_valid[i] == 2'b11) g = lastp[i] ? 0 : 1;
          else                       g = req_valid[i][1] ? 1 : 0;
          exp_ready = (g == 1) ? 2'b10 : 2'b01;
        end
        if (armed[i]) begin
          exp_clk = in_xfer && (((rel - 1) % (2*d)) >= d);
          check("csb", i, flash_csb[i], !in_xfer);
          check("flash_clk", i, flash_clk[i], exp_clk);
          if (!in_xfer) begin
            check("io0_idle", i, flash_io0[i], 1'b0);
          end else begin
            idx = (rel - 1) / (2*d);
            cmdaddr = {8'h03, m_addr[i]};
            if (idx < 32) check("io0_bit", i, flash_io0[i], cmdaddr[31-idx]);
          end
          check("rvalid", i, rvalid[i], done);
          check("req_ready", i, req_ready[i], exp_ready);
          check("rdata", i, rdata[i], h_data[i]);
          check("rid", i, rid[i], h_id[i]);
        end
        if (!resetb[i]) begin
          armed[i] = 1'b1; busy[i] = 1'b0; lastp[i] = 1'b1;
          h_data[i] = '0; h_id[i] = 1'b0;
        end else if (exp_ready != 2'b00) begin
          busy[i]   = 1'b1;
          t0[i]     = cyc;
          m_addr[i] = (g == 1) ? req_addr1[i] : req_addr0[i];
          m_id[i]   = (g == 1);
          lastp[i]  = (g == 1);
        end
      end
    end
  end

  task automatic wait_rv(input int i, input int n, input int budget);
    int k = 0;
    while (rv_cnt[i] < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (rv_cnt[i] < n) check("timeout_rvalid", i, rv_cnt[i], n);
  endtask

  task automatic wait_rises(input int i, input int n, input int budget);
    int k = 0;
    while (rises[i] < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (rises[i] < n) check("timeout_bits", i, rises[i], n);
  endtask

  initial begin
    int rv_before;
    resetb[0] = 1'b0;
    resetb[1] = 1'b0;
    push(0, 0, 24'h000100);
    push(0, 1, 24'h123456);
    push(1, 0, 24'h000200);
    push(1, 0, 24'h000200);

    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rst_csb", 0, flash_csb[0], 1'b1);
      check("rst_clk", 0, flash_clk[0], 1'b0);
      check("rst_rvalid", 0, rvalid[0], 1'b0);
      check("rst_ready", 0, req_ready[0], 2'b00);
    end
    @(posedge clock);
    #1;
    resetb[0] = 1'b1;
    resetb[1] = 1'b1;

    wait_rv(0, 2, 1500);
    check("lat_div2", 0, rv_cyc[0][0] - acc_cyc[0][0], 257);
    check("rdata_first", 0, rv_dat[0][0], 32'hEFBEADDE);
    check("rid_first", 0, rv_id[0][0], 1'b0);
    check("mosi_first", 0, rv_cmd[0][0], 32'h03000100);
    check("rid_second", 0, rv_id[0][1], 1'b1);
    check("mosi_second", 0, rv_cmd[0][1], 32'h03123456);

    wait_rv(1, 2, 600);
    check("lat_div1", 1, rv_cyc[1][0] - acc_cyc[1][0], 129);
    check("csb_gap_div1", 1, acc_cyc[1][1] - rv_cyc[1][0], 2);
    check("clk_period_div1", 1, rise_period[1], 2);
    check("rdata_div1", 1, rv_dat[1][0], 32'hEFBDADDE);

    push(0, 0, 24'h111111);
    push(0, 1, 24'h222222);
    push(0, 0, 24'h333333);
    push(0, 1, 24'h444444);
    wait_rv(0, 6, 3000);
    check("rr_order2", 0, rv_id[0][2], 1'b0);
    check("rr_order3", 0, rv_id[0][3], 1'b1);
    check("rr_order4", 0, rv_id[0][4], 1'b0);
    check("rr_order5", 0, rv_id[0][5], 1'b1);
    check("rr_data3", 0, rv_dat[0][3], le_pack(32'hDEADBEEF ^ 32'h00222322));

    push(0, 1, 24'hABCDEF);
    wait_rises(0, 31, 600);
    rv_before = rv_cnt[0];
    @(posedge clock);
    #1;
    resetb[0] = 1'b0;
    @(posedge clock);
    #1;
    resetb[0] = 1'b1;
    @(negedge clock);
    check("abort_csb", 0, flash_csb[0], 1'b1);
    repeat (400) @(negedge clock);
    check("abort_no_rvalid", 0, rv_cnt[0], rv_before);

    push(0, 0, 24'h0A0B0C);
    wait_rv(0, rv_before + 1, 600);
    check("restart_cmd", 0, rv_cmd[0][rv_before], 32'h030A0B0C);
    check("restart_rdata", 0, rv_dat[0][rv_before], 32'hE3B4A7DE);
    check("restart_rid", 0, rv_id[0][rv_before], 1'b0);

    repeat (10) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: flash_clk half-period in clock cycles; legal range 1..255.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port resetb  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req_valid  input  2  per-requester read request, and req_addr0/req_addr1  input  24 each  byte address.
REQ-005 SHALL have port req_ready  output  2  one-cycle accept pulse, at most one bit set.
REQ-006 SHALL have ports rdata  output  32  read word, rid  output  1  served requester, rvalid  output  1  one-cycle result strobe.
REQ-007 SHALL have ports flash_csb  output  1  chip select (active-low), flash_clk  output  1  SPI clock, flash_io0  output  1  MOSI, flash_io1  input  1  MISO.

Function
REQ-008 SHALL implement FSM IDLE -> XFER -> GAP -> IDLE.
REQ-009 In IDLE with any req_valid set, SHALL accept one requester: pulse its req_ready, latch its address, set rid, and enter XFER next cycle.
REQ-010 Arbitration SHALL be round-robin: if both are valid, grant the requester not most recently served; the last-served pointer resets to 1, so requester 0 wins first.
REQ-011 Requesters SHALL hold req_valid and address stable until req_ready; a dropped req_valid before accept is not served.
REQ-012 XFER SHALL shift 64 SPI mode-0 bits, MSB first: 8'h03, 24-bit address, then 32 data bits.
REQ-013 Each bit SHALL be flash_clk low for CLK_DIV cycles, then high for CLK_DIV cycles; flash_io0 updates on the first low-phase cycle; flash_io1 is sampled on the first high-phase cycle.
REQ-014 flash_csb SHALL be low for exactly the XFER state: from accept cycle T0+1 through cycle T0+128*CLK_DIV.
REQ-015 rvalid SHALL pulse at T0+1+128*CLK_DIV, coincident with flash_csb rising; rdata and rid SHALL hold until the next rvalid.
REQ-016 Data bytes SHALL pack little-endian: the first byte received goes to rdata[7:0], the fourth to rdata[31:24].
REQ-017 GAP SHALL hold flash_csb high and flash_clk low for 2*CLK_DIV cycles; no accept is allowed before GAP ends.
REQ-018 flash_io0 SHALL be 0 outside XFER; flash_clk SHALL idle low.
REQ-019 Requests arriving during XFER or GAP SHALL wait and SHALL NOT be dropped or reordered against round-robin.

Reset
REQ-020 With resetb low at a posedge, the next cycle SHALL have state IDLE, flash_csb=1, flash_clk=0, flash_io0=0, req_ready=0, rvalid=0, rdata=0, rid=0, and pointer=1.
REQ-021 Reset mid-XFER SHALL abort the transfer: flash_csb high the next cycle and no rvalid for the aborted transfer.

Structure
REQ-022 A shared package flash_ctrl_pkg SHALL hold the state enum, CMD_READ=8'h03, ADDR_BITS=24, DATA_BITS=32, and TOTAL_BITS=64.
REQ-023 Round-robin selection SHALL live in sub-module flash_rr_arb (inputs: valids, last pointer; outputs: one-hot grant).
REQ-024 The divider counter SHALL be 8 bits wide and the bit counter 7 bits wide.

Verification
REQ-025 Reset: hold resetb low 5 cycles, all inputs active -> flash_csb=1, flash_clk=0, rvalid=0, req_ready=0 throughout.
REQ-026 CLK_DIV=2, req0 addr 24'h000100, flash model returns DE AD BE EF -> io0 stream 03 00 01 00, rvalid at T0+257, rdata=32'hEFBEADDE, rid=0.
REQ-027 Both valid in the same cycle, held -> req0 served first, then req1; continuous contention alternates 0,1,0,1.
REQ-028 Reset pulsed during bit 30 -> flash_csb=1 the next cycle, no rvalid; the following request restarts with command 8'h03.
REQ-029 CLK_DIV=1 -> flash_clk period 2 cycles, rvalid at T0+129; back-to-back req0 -> flash_csb high exactly 2 cycles before the next T0.
